// File: rtl/sqrt_rem_unit_pkg.sv
// Shared definitions for the square-root unit: FSM state encoding and
// width helpers used by the controller, the datapath and the digit step.
package sqrt_rem_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width: enough to count WIDTH/2 digit steps.
   function automatic int cnt_width(input int width);
      return $clog2(width / 2 + 1);
   endfunction

   // Signed remainder width; wide enough that no trial subtraction overflows.
   function automatic int rem_width(input int width);
      return width / 2 + 2;
   endfunction

endpackage

// File: rtl/sqrt_rem_unit_ctrl.sv
// Controller: IDLE/CALC/DONE sequencing, digit counter and status flags.
module sqrt_rem_unit_ctrl
   import sqrt_rem_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic load,
   output logic step,
   output logic last,
   output logic busy,
   output logic ready
);

   localparam int CW = cnt_width(WIDTH);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (last)  state_next = DONE;
         DONE:    if (start) state_next = CALC;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == CALC);
      ready = (state == DONE);
      step  = (state == CALC);
      last  = (state == CALC) && (cnt == CW'(WIDTH / 2 - 1));
      load  = start && ((state == IDLE) || (state == DONE));
   end

endmodule

// File: rtl/sqrt_rem_unit_dp.sv
// Datapath: radicand shifter, partial root/remainder and result registers,
// with optional round-to-nearest applied when the last digit is written.
module sqrt_rem_unit_dp
   import sqrt_rem_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ROUND = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               last,
   input  logic [WIDTH-1:0]   num,
   output logic [WIDTH/2:0]   root,
   output logic [WIDTH/2:0]   rem
);

   localparam int H  = WIDTH / 2;
   localparam int RW = rem_width(WIDTH);

   logic        [WIDTH-1:0] shift_q;
   logic        [H-1:0]     root_q;
   logic signed [RW-1:0]    rem_q;
   logic        [H-1:0]     root_nx;
   logic signed [RW-1:0]    rem_nx;
   logic                    round_up;
   logic        [H:0]       root_final;

   sqrt_step #(.WIDTH(WIDTH)) u_step (
      .rem       (rem_q),
      .root      (root_q),
      .pair      (shift_q[WIDTH-1 -: 2]),
      .rem_next  (rem_nx),
      .root_next (root_nx)
   );

   // Rounding up is needed exactly when num lies past floor_root + 1/2.
   always_comb begin
      round_up   = (ROUND != 0) && (rem_nx > $signed({2'b00, root_nx}));
      root_final = {1'b0, root_nx} + {{H{1'b0}}, round_up};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         root    <= '0;
         rem     <= '0;
      end else if (load) begin
         shift_q <= num;
         root_q  <= '0;
         rem_q   <= '0;
      end else if (step) begin
         shift_q <= {shift_q[WIDTH-3:0], 2'b00};
         root_q  <= root_nx;
         rem_q   <= rem_nx;
         if (last) begin
            root <= root_final;
            rem  <= rem_nx[H:0];
         end
      end
   end

endmodule

// File: rtl/sqrt_step.sv
// One restoring square-root digit: brings down two radicand bits and
// tries to subtract {root, 01} from the widened remainder.
module sqrt_step
   import sqrt_rem_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic signed [rem_width(WIDTH)-1:0] rem,
   input  logic        [WIDTH/2-1:0]          root,
   input  logic        [1:0]                  pair,
   output logic signed [rem_width(WIDTH)-1:0] rem_next,
   output logic        [WIDTH/2-1:0]          root_next
);

   localparam int RW = rem_width(WIDTH);
   localparam int H  = WIDTH / 2;

   logic signed [RW-1:0] shifted;
   logic signed [RW-1:0] trial;

   // NOTE: every output of a combinational block gets a value on every path,
   // otherwise synthesis infers a latch to hold the old one.
   always_comb begin
      // Bits shifted out above RW cancel in the modular subtraction.
      shifted = RW'({rem, pair});
      trial   = shifted - {root, 2'b01};
      if (trial >= 0) begin
         rem_next  = trial;
         root_next = {root[H-2:0], 1'b1};
      end else begin
         rem_next  = shifted;
         root_next = {root[H-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sqrt_rem_unit.sv
// Multi-cycle integer square root with remainder: one root bit per cycle,
// WIDTH/2 cycles per operation, result held until the next start.
module sqrt_rem_unit #(
   parameter int WIDTH = 32,
   parameter int ROUND = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   num,
   output logic               busy,
   output logic               ready,
   output logic [WIDTH/2:0]   root,
   output logic [WIDTH/2:0]   rem
);

   logic load;
   logic step;
   logic last;

   sqrt_rem_unit_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .load  (load),
      .step  (step),
      .last  (last),
      .busy  (busy),
      .ready (ready)
   );

   sqrt_rem_unit_dp #(.WIDTH(WIDTH), .ROUND(ROUND)) u_dp (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .last (last),
      .num  (num),
      .root (root),
      .rem  (rem)
   );

endmodule
